// File: rtl/uart_pkg.sv
// Shared types and helpers for the queued UART.
// Holds FSM state encodings, frame bounds and the parity rule.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  localparam int IDX_W = $clog2(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Data is zero-padded to the widest frame, so padding never flips parity.
  function automatic logic parity_bit(
    input logic [MAX_DATA_BITS-1:0] d,
    input logic                     odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same clock.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d  = do_pop ? rd_q + PTR_ONE : rd_q;
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_fifo.sv
// Queued UART: TX/RX FIFOs, runtime parity and stop mode, per-byte errors.
// Serial timing is divider+1 clocks per bit; RX samples near mid-bit.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 ser_tx,
  input  logic                 ser_rx,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic                 enable,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_write,
  output logic                 tx_full,
  output logic                 tx_busy,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 clear_err
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic                 tx_push, tx_pop, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_full, rx_empty;
  logic [DATA_BITS+1:0] rx_din, rx_head;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  uart_sync_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (rx_push),
    .pop   (rx_read),
    .din   (rx_din),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  assign tx_push = tx_write && !tx_full;

  tx_state_e                tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]         tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0]     tx_shift_q, tx_shift_d;
  logic                     tx_par_q, tx_par_d;
  logic                     tx_pen_q, tx_pen_d;
  logic                     tx_two_q, tx_two_d;
  logic                     tx_tick, tx_try;
  logic [MAX_DATA_BITS-1:0] tx_pad;

  assign tx_tick = (tx_cnt_q == divider);
  assign tx_busy = !tx_empty || (tx_state_q != TX_IDLE);

  always_comb begin
    tx_pad = '0;
    tx_pad[DATA_BITS-1:0] = tx_head;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_two_d   = tx_two_q;
    tx_pop     = 1'b0;
    tx_try     = 1'b0;
    if (tx_state_q == TX_IDLE || tx_tick) tx_cnt_d = '0;
    unique case (tx_state_q)
      TX_IDLE: tx_try = 1'b1;
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = tx_idx_q + IDX_ONE;
          if (tx_idx_q == LAST_IDX)
            tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP1;
        end
      end
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP1;
      TX_STOP1: begin
        if (tx_tick) begin
          tx_state_d = tx_two_q ? TX_STOP2 : TX_IDLE;
          tx_try     = !tx_two_q;
        end
      end
      TX_STOP2: begin
        if (tx_tick) begin
          tx_state_d = TX_IDLE;
          tx_try     = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Chaining straight from the last stop bit keeps frames gapless.
    if (tx_try && enable && !tx_empty) begin
      tx_pop     = 1'b1;
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_shift_d = tx_head;
      tx_par_d   = parity_bit(tx_pad, parity_odd);
      tx_pen_d   = parity_en;
      tx_two_d   = two_stop;
    end
  end

  always_comb begin
    unique case (tx_state_q)
      TX_START:  ser_tx = 1'b0;
      TX_DATA:   ser_tx = tx_shift_q[0];
      TX_PARITY: ser_tx = tx_par_q;
      default:   ser_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_two_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_two_q   <= tx_two_d;
    end
  end

  logic                     rx_s1_q, rx_s1_d;
  logic                     rx_s2_q, rx_s2_d;
  logic                     rx_in;
  rx_state_e                rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]         rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0]     rx_shift_q, rx_shift_d;
  logic                     rx_perr_q, rx_perr_d;
  logic                     rx_pen_q, rx_pen_d;
  logic                     rx_odd_q, rx_odd_d;
  logic                     rx_ovr_q, rx_ovr_d;
  logic [DIV_WIDTH-1:0]     rx_half_m1;
  logic                     rx_tick;
  logic [MAX_DATA_BITS-1:0] rx_pad;

  assign rx_s1_d = ser_rx;
  assign rx_s2_d = rx_s1_q;
  assign rx_in   = rx_s2_q;

  // floor((divider+1)/2) - 1, written without a wider intermediate
  assign rx_half_m1 = (divider >> 1) + DIV_WIDTH'(divider[0]) - CNT_ONE;
  assign rx_tick = (rx_state_q == RX_START) ? (rx_cnt_q == rx_half_m1)
                                            : (rx_cnt_q == divider);

  always_comb begin
    rx_pad = '0;
    rx_pad[DATA_BITS-1:0] = rx_shift_q;
  end

  assign rx_din = {rx_perr_q, !rx_in, rx_shift_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + CNT_ONE;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (enable && !rx_in) begin
          rx_state_d = RX_START;
          rx_perr_d  = 1'b0;
          rx_pen_d   = parity_en;
          rx_odd_d   = parity_odd;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_state_d = rx_in ? RX_IDLE : RX_DATA;
          rx_idx_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
          rx_idx_d   = rx_idx_q + IDX_ONE;
          if (rx_idx_q == LAST_IDX)
            rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_perr_d  = rx_in != parity_bit(rx_pad, rx_odd_q);
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!enable && rx_state_q != RX_IDLE) begin
      rx_state_d = RX_IDLE;
      rx_push    = 1'b0;
    end
  end

  // A same-cycle read makes room, so only an unrelieved full push overruns.
  always_comb begin
    rx_ovr_d = rx_ovr_q;
    if (clear_err) rx_ovr_d = 1'b0;
    if (rx_push && rx_full && !rx_read) rx_ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_valid      = !rx_empty;
  assign rx_data       = rx_empty ? '1 : rx_head[DATA_BITS-1:0];
  assign rx_frame_err  = !rx_empty && rx_head[DATA_BITS];
  assign rx_parity_err = !rx_empty && rx_head[DATA_BITS+1];
  assign rx_overrun    = rx_ovr_q;

endmodule
